// File: rtl/id_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pipe_pkg
// Description : Shared definitions for the instruction-decode stage:
//               immediate-format encodings, default datapath width and
//               register count, the zero-register index, and a helper that
//               normalises an immediate field to 32 bits.
// Config      : none (the ID_BYPASS_EN option lives in id_regbank)
// Revision    : 1.0 - initial release
// ============================================================================
package id_pipe_pkg;

   localparam int c_def_word = 64;
   localparam int c_def_nreg = 32;
   localparam int c_xzr_idx  = c_def_nreg - 1;

   // Immediate formats selected by ImmSel
   typedef enum logic [1:0] {
      IMM_D  = 2'd0,   // imm9  [20:12], sign-extended
      IMM_I  = 2'd1,   // imm12 [21:10], zero-extended
      IMM_CB = 2'd2,   // imm19 [23:5],  sign-extended
      IMM_B  = 2'd3    // imm26 [25:0],  sign-extended
   } imm_sel_e;

   // Returns the selected immediate extended to 32 bits. The zero-extended
   // I format has a clear bit 31, so a later signed widening keeps it
   // positive and a single signed cast serves every format.
   function automatic logic [31:0] imm_ext32(input logic [31:0] inst,
                                             input imm_sel_e    sel);
      logic [31:0] v;
      case (sel)
         IMM_D:   v = {{23{inst[20]}}, inst[20:12]};
         IMM_I:   v = {20'd0, inst[21:10]};
         IMM_CB:  v = {{13{inst[23]}}, inst[23:5]};
         default: v = {{6{inst[25]}}, inst[25:0]};
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_regbank.sv
`default_nettype none
// ============================================================================
// Module      : id_regbank
// Description : Architectural register file for the decode stage. Two
//               combinational read ports, one write port. The top index
//               (XZR) always reads zero and ignores writes.
// Config      : ID_BYPASS_EN - when defined, a write in the same cycle as a
//               read of the same register returns the incoming write data;
//               otherwise the stored (old) value is returned.
// Ports       : clk, rst_n            clock, async active-low reset
//               rd_idx1/rd_data1      read port 1
//               rd_idx2/rd_data2      read port 2
//               we, wr_idx, wr_data   write port
// Revision    : 1.0 - initial release
// ============================================================================
module id_regbank
   import id_pipe_pkg::*;
#(
   parameter int WORD = c_def_word,
   parameter int NREG = c_def_nreg
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [$clog2(NREG)-1:0] rd_idx1,
   input  logic [$clog2(NREG)-1:0] rd_idx2,
   output logic [WORD-1:0]         rd_data1,
   output logic [WORD-1:0]         rd_data2,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] wr_idx,
   input  logic [WORD-1:0]         wr_data
);

   localparam int                c_iw  = $clog2(NREG);
   localparam logic [c_iw-1:0]   c_xzr = c_iw'(NREG - 1);

   logic [WORD-1:0] r_regs [NREG];
   logic            w_wr_en;
   logic            w_byp1;
   logic            w_byp2;

   // Writes aimed at the zero register are dropped here, so its storage
   // stays at its reset value of zero.
   assign w_wr_en = we & (wr_idx != c_xzr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[wr_idx] <= wr_data;
      end
   end

`ifdef ID_BYPASS_EN
   // w_wr_en already excludes XZR, so a forwarded value never leaks into a
   // zero-register read.
   assign w_byp1 = w_wr_en & (wr_idx == rd_idx1);
   assign w_byp2 = w_wr_en & (wr_idx == rd_idx2);
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
`endif

   assign rd_data1 = (rd_idx1 == c_xzr) ? '0 :
                     w_byp1             ? wr_data : r_regs[rd_idx1];
   assign rd_data2 = (rd_idx2 == c_xzr) ? '0 :
                     w_byp2             ? wr_data : r_regs[rd_idx2];

endmodule
`default_nettype wire

// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_pipe
// Description : Instruction-decode pipeline stage. Extracts register indices
//               and the immediate from the fetched instruction, reads the
//               register bank, detects load-use hazards against the
//               instruction in EX, and holds the result in the ID/EX
//               register (one cycle of latency).
// Config      : ID_BYPASS_EN - same-cycle write-back forwarding into the
//               register read data (implemented in id_regbank).
// Ports       : clk, rst_n                        clock, async active-low reset
//               inst, valid_in, ready_out          instruction handshake
//               Reg2Loc, WRegLoc, RegWrite,
//               MemRead, ImmSel                    decode controls for inst
//               stall_in, flush                    downstream hold / kill
//               wb_we, wb_reg, wb_data             write-back port
//               ex_*                               registered ID/EX outputs
//               hazard                             load-use stall active
// Revision    : 1.0 - initial release
// ============================================================================
module id_pipe
   import id_pipe_pkg::*;
#(
   parameter int WORD     = c_def_word,
   parameter int NREG     = c_def_nreg,
   parameter int LINK_REG = 30
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             inst,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic                    Reg2Loc,
   input  logic                    WRegLoc,
   input  logic                    RegWrite,
   input  logic                    MemRead,
   input  logic [1:0]              ImmSel,
   input  logic                    stall_in,
   input  logic                    flush,
   input  logic                    wb_we,
   input  logic [$clog2(NREG)-1:0] wb_reg,
   input  logic [WORD-1:0]         wb_data,
   output logic                    ex_valid,
   output logic                    ex_RegWrite,
   output logic                    ex_MemRead,
   output logic [$clog2(NREG)-1:0] ex_rd,
   output logic [$clog2(NREG)-1:0] ex_rn,
   output logic [$clog2(NREG)-1:0] ex_rm,
   output logic [WORD-1:0]         ex_r_data1,
   output logic [WORD-1:0]         ex_r_data2,
   output logic [WORD-1:0]         ex_ex_data,
   output logic                    hazard
);

   localparam int              c_iw   = $clog2(NREG);
   localparam logic [c_iw-1:0] c_xzr  = c_iw'(NREG - 1);
   localparam logic [c_iw-1:0] c_link = c_iw'(LINK_REG);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [c_iw-1:0] w_rn;
   logic [c_iw-1:0] w_rm;
   logic [c_iw-1:0] w_rd;
   logic [31:0]     w_imm32;
   logic [WORD-1:0] w_imm;
   logic [WORD-1:0] w_rdata1;
   logic [WORD-1:0] w_rdata2;
   logic            w_hazard;
   logic            w_unused_opc;

   assign w_rn = c_iw'(inst[9:5]);
   assign w_rm = Reg2Loc ? c_iw'(inst[4:0]) : c_iw'(inst[20:16]);
   assign w_rd = WRegLoc ? c_link : c_iw'(inst[4:0]);

   // Sign-carrying widen (or truncate when WORD < 32) to the datapath width.
   assign w_imm32 = imm_ext32(inst, imm_sel_e'(ImmSel));
   assign w_imm   = WORD'($signed(w_imm32));

   // Opcode bits are decoded upstream; only the operand fields matter here.
   assign w_unused_opc = &{1'b0, inst[31:26]};

   id_regbank #(
      .WORD (WORD),
      .NREG (NREG)
   ) u_regbank (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx1  (w_rn),
      .rd_idx2  (w_rm),
      .rd_data1 (w_rdata1),
      .rd_data2 (w_rdata2),
      .we       (wb_we),
      .wr_idx   (wb_reg),
      .wr_data  (wb_data)
   );

   // ------------------------------------------------------------------
   // Load-use hazard: a load in EX whose destination is a source of the
   // incoming instruction. Loads to XZR produce nothing to wait for.
   // ------------------------------------------------------------------
   logic            r_ex_valid;
   logic            r_ex_reg_write;
   logic            r_ex_mem_read;
   logic [c_iw-1:0] r_ex_rd;
   logic [c_iw-1:0] r_ex_rn;
   logic [c_iw-1:0] r_ex_rm;
   logic [WORD-1:0] r_ex_data1;
   logic [WORD-1:0] r_ex_data2;
   logic [WORD-1:0] r_ex_imm;

   assign w_hazard = r_ex_valid & r_ex_mem_read & valid_in &
                     (r_ex_rd != c_xzr) &
                     ((r_ex_rd == w_rn) | (r_ex_rd == w_rm));

   assign hazard    = w_hazard;
   assign ready_out = ~stall_in & ~w_hazard;

   // ------------------------------------------------------------------
   // ID/EX register. Priority: reset, flush, stall (hold), hazard
   // (bubble), load. Flush and bubble clear only the control bits; the
   // data fields keep whatever they held, as nothing downstream looks at
   // them while ex_valid is low.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid     <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_read  <= 1'b0;
         r_ex_rd        <= '0;
         r_ex_rn        <= '0;
         r_ex_rm        <= '0;
         r_ex_data1     <= '0;
         r_ex_data2     <= '0;
         r_ex_imm       <= '0;
      end else if (flush) begin
         r_ex_valid     <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_read  <= 1'b0;
      end else if (!stall_in) begin
         if (w_hazard) begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
         end else begin
            r_ex_valid     <= valid_in;
            r_ex_reg_write <= RegWrite & valid_in;
            r_ex_mem_read  <= MemRead & valid_in;
            r_ex_rd        <= w_rd;
            r_ex_rn        <= w_rn;
            r_ex_rm        <= w_rm;
            r_ex_data1     <= w_rdata1;
            r_ex_data2     <= w_rdata2;
            r_ex_imm       <= w_imm;
         end
      end
   end

   assign ex_valid    = r_ex_valid;
   assign ex_RegWrite = r_ex_reg_write;
   assign ex_MemRead  = r_ex_mem_read;
   assign ex_rd       = r_ex_rd;
   assign ex_rn       = r_ex_rn;
   assign ex_rm       = r_ex_rm;
   assign ex_r_data1  = r_ex_data1;
   assign ex_r_data2  = r_ex_data2;
   assign ex_ex_data  = r_ex_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_pipe
// Description : Self-checking bench for id_pipe. Directed scenarios followed
//               by randomized traffic, all compared against a behavioural
//               model of the decode stage kept in this file.
// Config      : honours ID_BYPASS_EN for the expected read-data behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_pipe;

   localparam int WORD     = 64;
   localparam int NREG     = 32;
   localparam int LINK_REG = 30;
`ifdef ID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        valid_in;
   logic        ready_out;
   logic        Reg2Loc, WRegLoc, RegWrite, MemRead;
   logic [1:0]  ImmSel;
   logic        stall_in, flush;
   logic        wb_we;
   logic [4:0]  wb_reg;
   logic [63:0] wb_data;
   logic        ex_valid, ex_RegWrite, ex_MemRead;
   logic [4:0]  ex_rd, ex_rn, ex_rm;
   logic [63:0] ex_r_data1, ex_r_data2, ex_ex_data;
   logic        hazard;

   always #5 clk = ~clk;

   id_pipe #(.WORD(WORD), .NREG(NREG), .LINK_REG(LINK_REG)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .valid_in(valid_in),
      .ready_out(ready_out), .Reg2Loc(Reg2Loc), .WRegLoc(WRegLoc),
      .RegWrite(RegWrite), .MemRead(MemRead), .ImmSel(ImmSel),
      .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_reg(wb_reg),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
      .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
      .ex_r_data1(ex_r_data1), .ex_r_data2(ex_r_data2),
      .ex_ex_data(ex_ex_data), .hazard(hazard)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [63:0] m_regs [32];
   bit          m_v, m_rw, m_mr;
   int          m_rd, m_rn, m_rm;
   logic [63:0] m_d1, m_d2, m_imm;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int src_n();
      return int'(inst[9:5]);
   endfunction

   function automatic int src_m();
      return Reg2Loc ? int'(inst[4:0]) : int'(inst[20:16]);
   endfunction

   function automatic bit m_hazard();
      return m_v && m_mr && valid_in && (m_rd != 31) &&
             ((m_rd == src_n()) || (m_rd == src_m()));
   endfunction

   function automatic logic [63:0] m_read(input int idx);
      if (idx == 31) return 64'd0;
      if (BYP && wb_we && int'(wb_reg) == idx) return wb_data;
      return m_regs[idx];
   endfunction

   // Immediate value as a plain signed integer, then as a 64-bit word.
   function automatic logic [63:0] m_immval();
      longint x;
      case (ImmSel)
         2'd0: begin x = longint'(inst[20:12]); if (x >= 256) x -= 512; end
         2'd1: x = longint'(inst[21:10]);
         2'd2: begin x = longint'(inst[23:5]); if (x >= 262144) x -= 524288; end
         default: begin x = longint'(inst[25:0]); if (x >= 33554432) x -= 67108864; end
      endcase
      return 64'(x);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_v = 0; m_rw = 0; m_mr = 0;
      m_rd = 0; m_rn = 0; m_rm = 0;
      m_d1 = 0; m_d2 = 0; m_imm = 0;
   endtask

   task automatic model_edge();
      bit hz;
      hz = m_hazard();
      if (flush) begin
         m_v = 0; m_rw = 0; m_mr = 0;
      end else if (!stall_in) begin
         if (hz) begin
            m_v = 0; m_rw = 0; m_mr = 0;
         end else begin
            m_v   = valid_in;
            m_rw  = RegWrite && valid_in;
            m_mr  = MemRead && valid_in;
            m_rd  = WRegLoc ? LINK_REG : int'(inst[4:0]);
            m_rn  = src_n();
            m_rm  = src_m();
            m_d1  = m_read(m_rn);
            m_d2  = m_read(m_rm);
            m_imm = m_immval();
         end
      end
      if (wb_we && wb_reg != 5'd31) m_regs[wb_reg] = wb_data;
   endtask

   // Called at posedge+1 with inputs already set; ends at the next posedge+1.
   task automatic cycle();
      bit hz;
      #1;
      hz = m_hazard();
      chk("hazard", hazard, hz);
      chk("ready_out", ready_out, !stall_in && !hz);
      @(posedge clk);
      model_edge();
      #1;
      chk("ex_valid", ex_valid, m_v);
      chk("ex_RegWrite", ex_RegWrite, m_rw);
      chk("ex_MemRead", ex_MemRead, m_mr);
      if (m_v) begin
         chk("ex_rd", ex_rd, m_rd);
         chk("ex_rn", ex_rn, m_rn);
         chk("ex_rm", ex_rm, m_rm);
         chk("ex_r_data1", ex_r_data1, m_d1);
         chk("ex_r_data2", ex_r_data2, m_d2);
         chk("ex_ex_data", ex_ex_data, m_imm);
      end
   endtask

   task automatic set_idle();
      inst = 32'd0; valid_in = 0; Reg2Loc = 0; WRegLoc = 0;
      RegWrite = 0; MemRead = 0; ImmSel = 2'd0;
      stall_in = 0; flush = 0; wb_we = 0; wb_reg = 5'd0; wb_data = 64'd0;
   endtask

   function automatic logic [31:0] mk_r(input int rd, input int rn, input int rm);
      return {11'h458, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
   endfunction

   function automatic logic [4:0] pick();
      int r;
      r = $urandom_range(0, 7);
      return (r == 7) ? 5'd31 : 5'(r);
   endfunction

   initial begin
      set_idle();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_ex_RegWrite", ex_RegWrite, 1'b0);
      chk("rst_ex_MemRead", ex_MemRead, 1'b0);
      chk("rst_ex_rd", ex_rd, 5'd0);
      chk("rst_ex_r_data1", ex_r_data1, 64'd0);
      chk("rst_ex_ex_data", ex_ex_data, 64'd0);
      chk("rst_hazard", hazard, 1'b0);
      chk("rst_ready", ready_out, 1'b1);
      rst_n = 1'b1;

      // write-back X3 then ADD X5,X3,X4
      wb_we = 1; wb_reg = 5'd3; wb_data = 64'h1234;
      cycle();
      wb_we = 0; inst = mk_r(5, 3, 4); valid_in = 1; RegWrite = 1;
      cycle();
      chk("add_data1", ex_r_data1, 64'h1234);
      chk("add_rd", ex_rd, 5'd5);
      chk("add_valid", ex_valid, 1'b1);

      // load-use: LDUR X2,[X1] then ADD X6,X2,X1
      inst = {11'h7C2, 9'd0, 2'b00, 5'd1, 5'd2}; MemRead = 1; RegWrite = 1;
      cycle();
      inst = mk_r(6, 2, 1); MemRead = 0;
      #1;
      chk("lu_hazard", hazard, 1'b1);
      chk("lu_ready", ready_out, 1'b0);
      cycle();
      chk("lu_bubble", ex_valid, 1'b0);
      cycle();
      chk("lu_issue_valid", ex_valid, 1'b1);
      chk("lu_issue_rn", ex_rn, 5'd2);

      // same-cycle write-back to a source register
      valid_in = 0; wb_we = 1; wb_reg = 5'd7; wb_data = 64'h11;
      cycle();
      wb_data = 64'hAA; inst = mk_r(8, 7, 0); valid_in = 1;
      cycle();
      chk("byp_data1", ex_r_data1, BYP ? 64'hAA : 64'h11);
      wb_we = 0;

      // hold for three stalled cycles, then flush over stall
      inst = mk_r(9, 3, 7);
      cycle();
      stall_in = 1; inst = mk_r(10, 1, 2);
      repeat (3) cycle();
      chk("stall_hold_rd", ex_rd, 5'd9);
      flush = 1;
      cycle();
      chk("flush_valid", ex_valid, 1'b0);
      flush = 0; stall_in = 0;

      // CB immediate all ones, BL link register, XZR
      inst = {8'hB4, 19'h7FFFF, 5'd0}; ImmSel = 2'd2; RegWrite = 0;
      cycle();
      chk("cb_imm", ex_ex_data, 64'hFFFF_FFFF_FFFF_FFFF);
      inst = {6'b100101, 26'h10}; ImmSel = 2'd3; WRegLoc = 1; RegWrite = 1;
      cycle();
      chk("bl_rd", ex_rd, 5'd30);
      WRegLoc = 0; valid_in = 0; wb_we = 1; wb_reg = 5'd31; wb_data = 64'h5;
      cycle();
      wb_we = 0; valid_in = 1; inst = mk_r(1, 31, 31);
      cycle();
      chk("xzr_read", ex_r_data1, 64'd0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         inst = $urandom;
         inst[4:0] = pick(); inst[9:5] = pick(); inst[20:16] = pick();
         valid_in = ($urandom_range(0, 9) < 8);
         Reg2Loc  = 1'($urandom_range(0, 1));
         WRegLoc  = ($urandom_range(0, 7) == 0);
         RegWrite = 1'($urandom_range(0, 1));
         MemRead  = ($urandom_range(0, 9) < 4);
         ImmSel   = 2'($urandom_range(0, 3));
         stall_in = ($urandom_range(0, 9) < 2);
         flush    = ($urandom_range(0, 9) == 0);
         wb_we    = ($urandom_range(0, 9) < 5);
         wb_reg   = pick();
         wb_data  = {$urandom, $urandom};
         cycle();
      end

      // asynchronous reset while stalled
      set_idle();
      inst = mk_r(4, 3, 7); valid_in = 1; RegWrite = 1;
      cycle();
      stall_in = 1;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", ex_valid, 1'b0);
      chk("arst_rd", ex_rd, 5'd0);
      chk("arst_data1", ex_r_data1, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1; stall_in = 0; valid_in = 0;
      #1;
      chk("arst_ready", ready_out, 1'b1);
      chk("arst_valid_after", ex_valid, 1'b0);
      for (int i = 0; i < 16; i++) begin
         inst = mk_r(0, 2 * i, 2 * i + 1); valid_in = 1; RegWrite = 0;
         cycle();
         chk("arst_reg_a", ex_r_data1, 64'd0);
         chk("arst_reg_b", ex_r_data2, 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
